// File: rtl/l2_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : l2_arbiter_pkg                                                 |
// | Brief   : Shared FSM states, requester IDs and logic constants.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package l2_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RETURN    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_INS = 2'd0,
    REQ_DRD = 2'd1,
    REQ_DWR = 2'd2
  } req_id_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/l2_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : l2_rr_arbiter                                                  |
// | Brief   : 2-way round-robin between I-side and data side.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module l2_rr_arbiter
  import l2_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_ins,
  input  logic i_req_data,
  input  logic i_advance,
  output logic o_gnt_ins,
  output logic o_gnt_data
);

  // Reset value LOW means the I-side was served last, so data side wins first.
  logic r_last_data;

  always_comb begin
    o_gnt_ins  = LOW;
    o_gnt_data = LOW;
    if (i_req_ins && i_req_data) begin
      o_gnt_data = ~r_last_data;
      o_gnt_ins  = r_last_data;
    end else begin
      o_gnt_data = i_req_data;
      o_gnt_ins  = i_req_ins;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= LOW;
    end else if (i_advance && (o_gnt_ins || o_gnt_data)) begin
      r_last_data <= o_gnt_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : l2_arbiter                                                     |
// | Brief   : Shares one L2 port between I-read, D-read and D-write.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int L2_BUS_WIDTH  = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  // I-fetch
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
  // D-read
  input  logic                     READ_ADDR_TO_L2_VALID_DATA,
  output logic                     READ_ADDR_TO_L2_READY_DATA,
  input  logic [ADDRESS_WIDTH-3:0] READ_ADDR_TO_L2_DATA,
  output logic                     DATA_FROM_L2_VALID_DATA,
  input  logic                     DATA_FROM_L2_READY_DATA,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_DATA,
  // D-write
  input  logic                     WRITE_TO_L2_VALID_DATA,
  output logic                     WRITE_TO_L2_READY_DATA,
  input  logic [ADDRESS_WIDTH-3:0] WRITE_ADDR_TO_L2_DATA,
  input  logic [L2_BUS_WIDTH-1:0]  DATA_TO_L2_DATA,
  input  logic                     WRITE_CONTROL_TO_L2_DATA,
  output logic                     WRITE_COMPLETE_DATA,
  // Memory
  output logic                     MEM_REQ_VALID,
  input  logic                     MEM_REQ_READY,
  output logic                     MEM_REQ_WE,
  output logic                     MEM_REQ_CTRL,
  output logic [ADDRESS_WIDTH-3:0] MEM_REQ_ADDR,
  output logic [L2_BUS_WIDTH-1:0]  MEM_REQ_WDATA,
  input  logic                     MEM_RESP_VALID,
  input  logic [L2_BUS_WIDTH-1:0]  MEM_RESP_DATA
);

  localparam int c_WORD_W = ADDRESS_WIDTH - 2;

  state_t                  r_state;
  state_t                  w_state_nxt;
  req_id_t                 r_req_id;
  logic [c_WORD_W-1:0]     r_addr;
  logic [L2_BUS_WIDTH-1:0] r_wdata;
  logic [L2_BUS_WIDTH-1:0] r_rdata;
  logic                    r_we;
  logic                    r_ctrl;
  logic                    r_wr_complete;

  logic w_idle;
  logic w_gnt_ins;
  logic w_gnt_data;
  logic w_grant;
  logic w_wr_sel;
  logic w_ret_ready;

  // READYs are gated by RST_N so they read low for the whole reset window.
  assign w_idle   = (r_state == ST_IDLE) && RST_N;
  assign w_wr_sel = WRITE_TO_L2_VALID_DATA;
  assign w_grant  = w_gnt_ins | w_gnt_data;

  l2_rr_arbiter u_rr (
    .clk        (CLK),
    .rst_n      (RST_N),
    .i_req_ins  (ADDRESS_TO_L2_VALID_INS & w_idle),
    .i_req_data ((WRITE_TO_L2_VALID_DATA | READ_ADDR_TO_L2_VALID_DATA) & w_idle),
    .i_advance  (w_grant),
    .o_gnt_ins  (w_gnt_ins),
    .o_gnt_data (w_gnt_data)
  );

  assign ADDRESS_TO_L2_READY_INS    = w_gnt_ins;
  assign WRITE_TO_L2_READY_DATA     = w_gnt_data & w_wr_sel;
  assign READ_ADDR_TO_L2_READY_DATA = w_gnt_data & ~w_wr_sel;

  assign MEM_REQ_WE          = r_we;
  assign MEM_REQ_CTRL        = r_ctrl;
  assign MEM_REQ_ADDR        = r_addr;
  assign MEM_REQ_WDATA       = r_wdata;
  assign DATA_FROM_L2_INS    = r_rdata;
  assign DATA_FROM_L2_DATA   = r_rdata;
  assign WRITE_COMPLETE_DATA = r_wr_complete;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt             = r_state;
    MEM_REQ_VALID           = LOW;
    DATA_FROM_L2_VALID_INS  = LOW;
    DATA_FROM_L2_VALID_DATA = LOW;
    w_ret_ready = (r_req_id == REQ_INS) ? DATA_FROM_L2_READY_INS
                                        : DATA_FROM_L2_READY_DATA;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        MEM_REQ_VALID = HIGH;
        if (MEM_REQ_READY) w_state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (MEM_RESP_VALID) w_state_nxt = r_we ? ST_IDLE : ST_RETURN;
      end
      ST_RETURN: begin
        DATA_FROM_L2_VALID_INS  = (r_req_id == REQ_INS);
        DATA_FROM_L2_VALID_DATA = (r_req_id == REQ_DRD);
        if (w_ret_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_req_id      <= REQ_INS;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_we          <= LOW;
      r_ctrl        <= LOW;
      r_wr_complete <= LOW;
    end else begin
      r_wr_complete <= LOW;
      if (w_grant) begin
        if (w_gnt_ins) begin
          r_addr   <= ADDRESS_TO_L2_INS;
          r_we     <= LOW;
          r_ctrl   <= LOW;
          r_req_id <= REQ_INS;
        end else if (w_wr_sel) begin
          r_addr   <= WRITE_ADDR_TO_L2_DATA;
          r_wdata  <= DATA_TO_L2_DATA;
          r_we     <= HIGH;
          r_ctrl   <= WRITE_CONTROL_TO_L2_DATA;
          r_req_id <= REQ_DWR;
        end else begin
          r_addr   <= READ_ADDR_TO_L2_DATA;
          r_we     <= LOW;
          r_ctrl   <= LOW;
          r_req_id <= REQ_DRD;
        end
      end
      // Responses outside WAIT_RESP are stray and dropped.
      if ((r_state == ST_WAIT_RESP) && MEM_RESP_VALID) begin
        if (r_we) r_wr_complete <= HIGH;
        else      r_rdata       <= MEM_RESP_DATA;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_l2_arbiter                                                  |
// | Brief   : Directed self-checking bench for l2_arbiter.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_l2_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        ADDRESS_TO_L2_VALID_INS;
  logic        ADDRESS_TO_L2_READY_INS;
  logic [29:0] ADDRESS_TO_L2_INS;
  logic        DATA_FROM_L2_VALID_INS;
  logic        DATA_FROM_L2_READY_INS;
  logic [31:0] DATA_FROM_L2_INS;
  logic        READ_ADDR_TO_L2_VALID_DATA;
  logic        READ_ADDR_TO_L2_READY_DATA;
  logic [29:0] READ_ADDR_TO_L2_DATA;
  logic        DATA_FROM_L2_VALID_DATA;
  logic        DATA_FROM_L2_READY_DATA;
  logic [31:0] DATA_FROM_L2_DATA;
  logic        WRITE_TO_L2_VALID_DATA;
  logic        WRITE_TO_L2_READY_DATA;
  logic [29:0] WRITE_ADDR_TO_L2_DATA;
  logic [31:0] DATA_TO_L2_DATA;
  logic        WRITE_CONTROL_TO_L2_DATA;
  logic        WRITE_COMPLETE_DATA;
  logic        MEM_REQ_VALID;
  logic        MEM_REQ_READY;
  logic        MEM_REQ_WE;
  logic        MEM_REQ_CTRL;
  logic [29:0] MEM_REQ_ADDR;
  logic [31:0] MEM_REQ_WDATA;
  logic        MEM_RESP_VALID;
  logic [31:0] MEM_RESP_DATA;

  int total = 0;
  int bad   = 0;

  l2_arbiter #(.ADDRESS_WIDTH(32), .L2_BUS_WIDTH(32)) dut (
    .CLK                        (CLK),
    .RST_N                      (RST_N),
    .ADDRESS_TO_L2_VALID_INS    (ADDRESS_TO_L2_VALID_INS),
    .ADDRESS_TO_L2_READY_INS    (ADDRESS_TO_L2_READY_INS),
    .ADDRESS_TO_L2_INS          (ADDRESS_TO_L2_INS),
    .DATA_FROM_L2_VALID_INS     (DATA_FROM_L2_VALID_INS),
    .DATA_FROM_L2_READY_INS     (DATA_FROM_L2_READY_INS),
    .DATA_FROM_L2_INS           (DATA_FROM_L2_INS),
    .READ_ADDR_TO_L2_VALID_DATA (READ_ADDR_TO_L2_VALID_DATA),
    .READ_ADDR_TO_L2_READY_DATA (READ_ADDR_TO_L2_READY_DATA),
    .READ_ADDR_TO_L2_DATA       (READ_ADDR_TO_L2_DATA),
    .DATA_FROM_L2_VALID_DATA    (DATA_FROM_L2_VALID_DATA),
    .DATA_FROM_L2_READY_DATA    (DATA_FROM_L2_READY_DATA),
    .DATA_FROM_L2_DATA          (DATA_FROM_L2_DATA),
    .WRITE_TO_L2_VALID_DATA     (WRITE_TO_L2_VALID_DATA),
    .WRITE_TO_L2_READY_DATA     (WRITE_TO_L2_READY_DATA),
    .WRITE_ADDR_TO_L2_DATA      (WRITE_ADDR_TO_L2_DATA),
    .DATA_TO_L2_DATA            (DATA_TO_L2_DATA),
    .WRITE_CONTROL_TO_L2_DATA   (WRITE_CONTROL_TO_L2_DATA),
    .WRITE_COMPLETE_DATA        (WRITE_COMPLETE_DATA),
    .MEM_REQ_VALID              (MEM_REQ_VALID),
    .MEM_REQ_READY              (MEM_REQ_READY),
    .MEM_REQ_WE                 (MEM_REQ_WE),
    .MEM_REQ_CTRL               (MEM_REQ_CTRL),
    .MEM_REQ_ADDR               (MEM_REQ_ADDR),
    .MEM_REQ_WDATA              (MEM_REQ_WDATA),
    .MEM_RESP_VALID             (MEM_RESP_VALID),
    .MEM_RESP_DATA              (MEM_RESP_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory accepts at once and answers in the following cycle.
  task automatic serve_read(input logic [31:0] rd);
    MEM_REQ_READY = 1'b1;
    cyc();
    MEM_RESP_VALID = 1'b1;
    MEM_RESP_DATA  = rd;
    cyc();
    MEM_RESP_VALID = 1'b0;
  endtask

  initial begin
    logic [31:0] stored;
    logic        exp_d;

    RST_N = 1'b0;
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS = '0;
    DATA_FROM_L2_READY_INS = 1'b0;
    READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    READ_ADDR_TO_L2_DATA = '0;
    DATA_FROM_L2_READY_DATA = 1'b0;
    WRITE_TO_L2_VALID_DATA = 1'b0;
    WRITE_ADDR_TO_L2_DATA = '0;
    DATA_TO_L2_DATA = '0;
    WRITE_CONTROL_TO_L2_DATA = 1'b0;
    MEM_REQ_READY = 1'b0;
    MEM_RESP_VALID = 1'b0;
    MEM_RESP_DATA = '0;
    stored = '0;
    cyc();
    cyc();

    // Reset state
    chk("rst_ready_ins", ADDRESS_TO_L2_READY_INS, 0);
    chk("rst_mem_valid", MEM_REQ_VALID, 0);
    chk("rst_ret_ins",   DATA_FROM_L2_VALID_INS, 0);
    chk("rst_complete",  WRITE_COMPLETE_DATA, 0);
    chk("rst_addr",      MEM_REQ_ADDR, 0);
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    RST_N = 1'b1;

    // Stray response in IDLE is ignored
    MEM_RESP_VALID = 1'b1;
    MEM_RESP_DATA  = 32'h1234_5678;
    cyc();
    MEM_RESP_VALID = 1'b0;
    chk("idle_resp_ignored", DATA_FROM_L2_VALID_INS | DATA_FROM_L2_VALID_DATA, 0);

    // Single I-read at byte 0x4 (word 1)
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS = 30'h1;
    #1;
    chk("i_grant_ready", ADDRESS_TO_L2_READY_INS, 1);
    chk("i_grant_rd_rdy", READ_ADDR_TO_L2_READY_DATA, 0);
    cyc();
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    chk("i_req_valid", MEM_REQ_VALID, 1);
    chk("i_req_addr",  MEM_REQ_ADDR, 30'h1);
    chk("i_req_we",    MEM_REQ_WE, 0);
    chk("i_req_ctrl",  MEM_REQ_CTRL, 0);
    chk("i_ready_busy", ADDRESS_TO_L2_READY_INS, 0);
    serve_read(32'h00A0_0093);
    chk("i_ret_valid", DATA_FROM_L2_VALID_INS, 1);
    chk("i_ret_data",  DATA_FROM_L2_INS, 32'h00A0_0093);
    chk("i_ret_other", DATA_FROM_L2_VALID_DATA, 0);
    cyc();
    cyc();
    chk("i_ret_hold_valid", DATA_FROM_L2_VALID_INS, 1);
    chk("i_ret_hold_data",  DATA_FROM_L2_INS, 32'h00A0_0093);
    DATA_FROM_L2_READY_INS = 1'b1;
    cyc();
    DATA_FROM_L2_READY_INS = 1'b0;
    chk("i_ret_done", DATA_FROM_L2_VALID_INS, 0);

    // Write and read to byte 0x10 (word 4) in the same cycle: write first
    WRITE_TO_L2_VALID_DATA = 1'b1;
    WRITE_ADDR_TO_L2_DATA = 30'h4;
    DATA_TO_L2_DATA = 32'hDEAD_BEEF;
    WRITE_CONTROL_TO_L2_DATA = 1'b1;
    READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    READ_ADDR_TO_L2_DATA = 30'h4;
    MEM_REQ_READY = 1'b0;
    #1;
    chk("wr_first_wready", WRITE_TO_L2_READY_DATA, 1);
    chk("wr_first_rready", READ_ADDR_TO_L2_READY_DATA, 0);
    cyc();
    WRITE_TO_L2_VALID_DATA = 1'b0;
    chk("wr_req_we",   MEM_REQ_WE, 1);
    chk("wr_req_ctrl", MEM_REQ_CTRL, 1);

    // Memory stalls for 5 cycles
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", MEM_REQ_VALID, 1);
      chk("stall_addr",  MEM_REQ_ADDR, 30'h4);
      chk("stall_wdata", MEM_REQ_WDATA, 32'hDEAD_BEEF);
      chk("stall_rready", READ_ADDR_TO_L2_READY_DATA, 0);
      cyc();
    end
    MEM_REQ_READY = 1'b1;
    stored = MEM_REQ_WDATA;
    cyc();
    MEM_RESP_VALID = 1'b1;
    cyc();
    MEM_RESP_VALID = 1'b0;
    chk("wr_complete", WRITE_COMPLETE_DATA, 1);
    chk("wr_no_return", DATA_FROM_L2_VALID_DATA, 0);
    chk("rd_after_wr_ready", READ_ADDR_TO_L2_READY_DATA, 1);
    cyc();
    READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    chk("wr_complete_pulse", WRITE_COMPLETE_DATA, 0);
    chk("rd_req_we",   MEM_REQ_WE, 0);
    chk("rd_req_ctrl", MEM_REQ_CTRL, 0);
    chk("rd_req_addr", MEM_REQ_ADDR, 30'h4);
    serve_read(stored);
    chk("rd_ret_valid", DATA_FROM_L2_VALID_DATA, 1);
    chk("rd_ret_data",  DATA_FROM_L2_DATA, 32'hDEAD_BEEF);
    chk("rd_ret_other", DATA_FROM_L2_VALID_INS, 0);

    // Return held for 4 cycles with an I-request waiting
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS = 30'h2;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", DATA_FROM_L2_VALID_DATA, 1);
      chk("hold_data",  DATA_FROM_L2_DATA, 32'hDEAD_BEEF);
      chk("hold_no_grant", ADDRESS_TO_L2_READY_INS, 0);
      chk("hold_no_req", MEM_REQ_VALID, 0);
      cyc();
    end
    DATA_FROM_L2_READY_DATA = 1'b1;
    cyc();
    DATA_FROM_L2_READY_DATA = 1'b0;
    #1;
    chk("lone_i_ready", ADDRESS_TO_L2_READY_INS, 1);
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    #1;
    chk("withdrawn_ready", ADDRESS_TO_L2_READY_INS, 0);
    cyc();
    chk("withdrawn_no_req", MEM_REQ_VALID, 0);

    // Reset during WAIT_RESP
    READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    READ_ADDR_TO_L2_DATA = 30'h7;
    cyc();
    READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    MEM_REQ_READY = 1'b1;
    chk("abort_req_addr", MEM_REQ_ADDR, 30'h7);
    cyc();
    chk("abort_waiting", MEM_REQ_VALID, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("abort_addr_clr", MEM_REQ_ADDR, 0);
    chk("abort_ret", DATA_FROM_L2_VALID_DATA, 0);
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    #1;
    chk("abort_ready_low", ADDRESS_TO_L2_READY_INS, 0);
    cyc();
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    RST_N = 1'b1;
    MEM_RESP_VALID = 1'b1;
    MEM_RESP_DATA = 32'h0000_0BAD;
    cyc();
    MEM_RESP_VALID = 1'b0;
    chk("late_resp_d", DATA_FROM_L2_VALID_DATA, 0);
    chk("late_resp_i", DATA_FROM_L2_VALID_INS, 0);
    cyc();
    chk("late_resp_d2", DATA_FROM_L2_VALID_DATA, 0);
    chk("late_resp_req", MEM_REQ_VALID, 0);

    // Contended I-read and D-read: D,I,D,I,... from reset
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS = 30'h10;
    READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    READ_ADDR_TO_L2_DATA = 30'h20;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_d = (i % 2 == 0);
      chk("rr_ready_d", READ_ADDR_TO_L2_READY_DATA, exp_d);
      chk("rr_ready_i", ADDRESS_TO_L2_READY_INS, !exp_d);
      cyc();
      chk("rr_addr", MEM_REQ_ADDR, exp_d ? 30'h20 : 30'h10);
      serve_read(32'h100 + i);
      chk("rr_ret_d", DATA_FROM_L2_VALID_DATA, exp_d);
      chk("rr_ret_i", DATA_FROM_L2_VALID_INS, !exp_d);
      chk("rr_ret_data", exp_d ? DATA_FROM_L2_DATA : DATA_FROM_L2_INS, 32'h100 + i);
      DATA_FROM_L2_READY_INS = 1'b1;
      DATA_FROM_L2_READY_DATA = 1'b1;
      cyc();
      DATA_FROM_L2_READY_INS = 1'b0;
      DATA_FROM_L2_READY_DATA = 1'b0;
      #1;
    end
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameters: ADDRESS_WIDTH, default 32, byte-address width (word address = ADDRESS_WIDTH-2 = 30 bits); L2_BUS_WIDTH, default 32, L2 data bus width.
REQ-002 Ports: CLK, in, 1, the single clock; all state changes on its rising edge.
REQ-003 Ports: RST_N, in, 1, asynchronous active-low reset.
REQ-004 I-fetch side: ADDRESS_TO_L2_VALID_INS in 1; ADDRESS_TO_L2_READY_INS out 1; ADDRESS_TO_L2_INS in 30, word address.
REQ-005 I-return side: DATA_FROM_L2_VALID_INS out 1; DATA_FROM_L2_READY_INS in 1; DATA_FROM_L2_INS out 32.
REQ-006 D-read side: READ_ADDR_TO_L2_VALID_DATA in 1; READ_ADDR_TO_L2_READY_DATA out 1; READ_ADDR_TO_L2_DATA in 30; DATA_FROM_L2_VALID_DATA out 1; DATA_FROM_L2_READY_DATA in 1; DATA_FROM_L2_DATA out 32.
REQ-007 D-write side: WRITE_TO_L2_VALID_DATA in 1; WRITE_TO_L2_READY_DATA out 1; WRITE_ADDR_TO_L2_DATA in 30; DATA_TO_L2_DATA in 32; WRITE_CONTROL_TO_L2_DATA in 1; WRITE_COMPLETE_DATA out 1.
REQ-008 Memory side: MEM_REQ_VALID out 1; MEM_REQ_READY in 1; MEM_REQ_WE out 1; MEM_REQ_CTRL out 1; MEM_REQ_ADDR out 30; MEM_REQ_WDATA out 32; MEM_RESP_VALID in 1; MEM_RESP_DATA in 32.

Function
REQ-009 The block SHALL share one L2 port between three requesters (I-read, D-read, D-write), with exactly one transaction outstanding at any time.
REQ-010 FSM states: IDLE, ISSUE, WAIT_RESP, RETURN. IDLE->ISSUE on grant; ISSUE->WAIT_RESP on MEM_REQ_READY; WAIT_RESP->RETURN on MEM_RESP_VALID for reads, and ->IDLE for writes; RETURN->IDLE on the requester's return READY.
REQ-011 Grant in IDLE: the winner's address READY SHALL be driven combinationally high; the handshake completes at the edge where VALID and READY are both high. All other READYs SHALL be low outside IDLE.
REQ-012 Priority, data side: D-write SHALL win over D-read, which preserves read-after-write order.
REQ-013 Priority, data side vs I-side: when both have requests pending, grant SHALL alternate using a registered last-grant flag (round-robin). A lone requester SHALL be granted immediately.
REQ-014 On grant, address, write data, WE (1 for write, 0 for read), CTRL and requester ID SHALL be registered.
REQ-015 MEM_REQ_VALID SHALL be high in the cycle after grant and held with stable ADDR, WE, CTRL and WDATA until MEM_REQ_READY.
REQ-016 MEM_REQ_CTRL SHALL equal the captured WRITE_CONTROL_TO_L2_DATA for writes and 0 for reads.
REQ-017 Read return: MEM_RESP_DATA SHALL be registered on MEM_RESP_VALID.
REQ-018 The matching DATA_FROM_L2_VALID_* SHALL go high the next cycle, holding the data stable until its READY; the other side's VALID SHALL stay low.
REQ-019 Write completion: WRITE_COMPLETE_DATA SHALL pulse high for exactly 1 cycle, the cycle after MEM_RESP_VALID.
REQ-020 MEM_RESP_VALID in IDLE or ISSUE SHALL be ignored.
REQ-021 Minimum read latency, grant to return-valid: 3 cycles with MEM_REQ_READY=1 and the response in the cycle after the request is accepted.
REQ-022 A requester's VALID dropping before its grant SHALL cancel nothing already in flight; the arbiter SHALL simply not grant it.

Reset
REQ-023 While RST_N=0: FSM=IDLE; all VALID/READY/COMPLETE outputs=0; data, address and WDATA registers=0; last-grant=I-side, so the first contended grant goes to the data side.
REQ-024 Reset mid-transaction SHALL abort immediately; no response SHALL be delivered after release.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the requester-ID encoding (REQ_INS, REQ_DRD, REQ_DWR), and the HIGH/LOW constants.
REQ-026 One sub-module, l2_rr_arbiter (2-way round-robin with the registered last-grant flag), SHALL be used; the FSM and datapath SHALL live in the top.

Verification
REQ-027 Single I-read at address 0x4, memory returns 0x00A00093 -> DATA_FROM_L2_INS=0x00A00093 with VALID 3 cycles after grant; held until READY.
REQ-028 D-write and D-read asserted in the same cycle to address 0x10, write data 0xDEADBEEF -> write issued first and WRITE_COMPLETE pulses once; the read then returns 0xDEADBEEF.
REQ-029 I-read and D-read held continuously for 8 transactions -> grants strictly alternate D,I,D,I... starting with D.
REQ-030 MEM_REQ_READY held low 5 cycles -> MEM_REQ_VALID, ADDR and WDATA stay stable all 5 cycles.
REQ-031 DATA_FROM_L2_READY_DATA held low 4 cycles in RETURN -> data stable, no new grant issued.
REQ-032 RST_N asserted in WAIT_RESP -> all outputs 0 asynchronously; a late MEM_RESP_VALID after release produces no return.
